// File: rtl/rvvi_retire_queue.sv
// rvvi_retire_queue
//   Accepts up to NRET retired-instruction records per cycle, packs the valid
//   lanes into consecutive slots of a DEPTH-entry FIFO and presents them one at
//   a time on a single-lane stream with a running 64-bit retire order number.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   flush                 synchronous queue clear (order number is kept)
//   in_valid/insn/pc/     NRET-lane retire group; lane i occupies slice i
//   in_trap/in_mode
//   in_ready              room for a full NRET group (depends on count only)
//   out_valid/out_ready   head handshake
//   out_insn/pc/trap/mode head record, zero while the queue is empty
//   out_order             order number of the head record (starts at 1)
//   count                 occupied entries
module rvvi_retire_queue #(
  parameter int XLEN  = 64,
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NRET-1:0]           in_valid,
  input  logic [NRET*32-1:0]        in_insn,
  input  logic [NRET*XLEN-1:0]      in_pc,
  input  logic [NRET-1:0]           in_trap,
  input  logic [NRET*2-1:0]         in_mode,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_insn,
  output logic [XLEN-1:0]           out_pc,
  output logic                      out_trap,
  output logic [1:0]                out_mode,
  output logic [63:0]               out_order,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Highest occupancy that still leaves room for a whole NRET group.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - NRET);

  logic [31:0]     r_insn [DEPTH];
  logic [XLEN-1:0] r_pc   [DEPTH];
  logic            r_trap [DEPTH];
  logic [1:0]      r_mode [DEPTH];

  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [CW-1:0]   r_count;
  logic [63:0]     r_order;

  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_npush;
  logic [AW-1:0]   w_idx [NRET];

  // Each valid lane lands at wp plus the number of valid lanes below it, so
  // gaps in in_valid never leave holes in the FIFO.
  always_comb begin
    w_npush = '0;
    for (int i = 0; i < NRET; i++) begin
      w_idx[i] = r_wp + w_npush[AW-1:0];
      w_npush  = w_npush + CW'(in_valid[i]);
    end
  end

  assign in_ready  = (r_count <= READY_MAX);
  assign out_valid = (r_count != '0);
  assign w_push    = in_ready & (|in_valid);
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_order <= 64'd1;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + w_npush[AW-1:0];
      if (w_pop) begin
        r_rp    <= r_rp + AW'(1);
        r_order <= r_order + 64'd1;
      end
      r_count <= r_count + (w_push ? w_npush : '0) - (w_pop ? CW'(1) : '0);
    end
  end

  // Storage carries no reset; stale slots are masked by count.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      for (int i = 0; i < NRET; i++) begin
        if (in_valid[i]) begin
          r_insn[w_idx[i]] <= in_insn[32*i +: 32];
          r_pc[w_idx[i]]   <= in_pc[XLEN*i +: XLEN];
          r_trap[w_idx[i]] <= in_trap[i];
          r_mode[w_idx[i]] <= in_mode[2*i +: 2];
        end
      end
    end
  end

  assign out_insn  = out_valid ? r_insn[r_rp] : '0;
  assign out_pc    = out_valid ? r_pc[r_rp]   : '0;
  assign out_trap  = out_valid ? r_trap[r_rp] : 1'b0;
  assign out_mode  = out_valid ? r_mode[r_rp] : '0;
  assign out_order = r_order;
  assign count     = r_count;

endmodule

// File: doc/rvvi_retire_queue.md
# rvvi_retire_queue

Synthesizable multi-lane retire-trace queue that accepts up to NRET retired-instruction records per cycle from a core's RVVI-style retire port. It compacts the valid lanes, buffers them in a DEPTH-entry FIFO, and serialises them to a single-lane stream with backpressure and a monotonically increasing order number. It sits between the core's retire stage and the coverage/trace consumer, and replaces file-driven single-instruction injection with a hardware path.

## Interface
- XLEN, 64: register/PC width (32 or 64)
- NRET, 2: input retire lanes per cycle (1–4)
- DEPTH, 8: FIFO entries; must be a power of two and at least NRET
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous queue clear; order counter preserved
- in_valid  in  NRET  per-lane record valid
- in_insn  in  NRET*32  lane i at [32i+31:32i]
- in_pc  in  NRET*XLEN  lane i at [XLEN*i+XLEN-1:XLEN*i]
- in_trap  in  NRET  per-lane trap flag
- in_mode  in  NRET*2  per-lane privilege mode
- in_ready  out  1  queue can accept a full NRET-lane group this cycle
- out_valid  out  1  head record present
- out_ready  in  1  consumer accepts head
- out_insn  out  32  head instruction
- out_pc  out  XLEN  head PC
- out_trap  out  1  head trap flag
- out_mode  out  2  head mode
- out_order  out  64  retire order number of head
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Entry = {insn, pc, trap, mode}, stored in a DEPTH-deep array with write pointer wp, read pointer rp and count.
- in_ready = (DEPTH − count) ≥ NRET. It is a function of registered count only, never of in_valid or out_ready.
- Push when in_ready & |in_valid:
  - Valid lanes are written in ascending lane order to wp, wp+1, …
  - Invalid lanes are skipped with no gap: valid lanes {0,2} occupy two consecutive entries.
  - wp and count advance by popcount(in_valid).
  - If in_ready=0, inputs are ignored. The producer holds them, and lanes are never partially accepted.
- Pop when out_valid & out_ready: rp advances by 1, and the order register increments by 1.
- Simultaneous push and pop: count_next = count + popcount − 1. Both take effect on the same edge.
- Pointers wrap modulo DEPTH using natural wrap of $clog2(DEPTH)-bit pointers.
- out_valid = (count ≠ 0).
- out_insn/pc/trap/mode = array[rp] when out_valid is high, and all-zero when out_valid is low.
- out_order = order register.
  - Value is 1 after reset, so the first emitted record carries order 1.
  - Wraps at 2^64 without a flag.
- flush:
  - wp, rp and count are set to 0 on the next edge.
  - Any push or pop in the same cycle is discarded, and order does not increment.
  - The order register keeps its value.
- Reset (asynchronous, any time including mid-push): wp=rp=count=0, order=1, out_valid=0, out data=0, in_ready=1. Array contents are don't-care.

## Timing
- Push-to-output latency is 1 cycle: a record accepted at edge t gives out_valid=1 with that data after edge t.
- No combinational path from in_* to out_*, or from out_ready to in_ready.
- Output stability: while out_valid & !out_ready, all out_* hold stable, regardless of pushes.
- Full throughput: one pop per cycle sustained. Input bursts of NRET per cycle are accepted until count > DEPTH − NRET.
- flush takes priority over push and pop. Reset takes priority over everything.

## Test plan
- **Reset:** assert reset mid-burst with count=5.
  - During reset: count=0, out_valid=0, out_order=1, in_ready=1.
  - After release: the first push of insn 0x00000013 emits order 1.
- **Lane compaction:** with NRET=2, in_valid=2'b10, lane1 insn=0x00A00093 and pc=0x80000004.
  - Required: count=1, out_insn=0x00A00093, out_pc=0x80000004 one cycle later.
  - Then in_valid=2'b11 emits lane0 before lane1.
- **Fill/backpressure:** with DEPTH=8, NRET=2, out_ready=0, push 2 lanes per cycle.
  - in_ready drops when count=7 or 8: after 4 pushes count=8 and in_ready=0.
  - Held inputs are accepted only after pops free 2 entries.
- **Simultaneous push/pop:** count=3, out_ready=1, push 2 lanes.
  - Required: count=4 next cycle and out_order increments by exactly 1.
- **Wrap:** stream 20 records through DEPTH=8 with random out_ready.
  - Required: output sequence equals input sequence, and out_order runs 1..20 with no gaps or duplicates.
- **Flush:** count=6, out_order=10, assert flush with a concurrent push and pop.
  - Required next cycle: count=0, out_valid=0, out_order=10.
  - The next pushed record emits with order 10.
